// File: rtl/fpu_defs_pkg.sv
// Shared COP1 definitions used by the FPU and its issue stage: opcode and
// format encodings, the NOP word, the tracker-slot layout and the decoder.
package fpu_defs;

  localparam logic [5:0]  OP_COP1  = 6'h11;
  localparam logic [4:0]  FMT_MF   = 5'h00;
  localparam logic [4:0]  FMT_MT   = 5'h04;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // One pipeline-tracker slot. dst holds the FPR pair index reg[4:1].
  typedef struct packed {
    logic       valid;
    logic       dst_v;
    logic [3:0] dst;
    logic       mfc;
    logic       mtc;
    logic [4:0] rt;
  } trk_slot_t;

  // Decoded view of an instruction: FPR pair sources plus its tracker slot.
  typedef struct packed {
    logic       src_a_v;
    logic [3:0] src_a;
    logic       src_b_v;
    logic [3:0] src_b;
    trk_slot_t  slot;
  } dec_t;

  // Field extraction mirrors the FPU decoder. Non-COP1 words and COP1 forms
  // that are neither moves nor arithmetic get no source and no destination.
  function automatic dec_t decode(input logic [31:0] inst);
    dec_t       d;
    logic       cop1;
    logic       low_zero;
    logic [4:0] fmt;
    logic [4:0] ft;
    logic [4:0] fs;
    logic [4:0] fd;
    d          = '0;
    d.slot.valid = 1'b1;
    cop1       = (inst[31:26] == OP_COP1);
    low_zero   = (inst[10:0] == 11'h0);
    fmt        = inst[25:21];
    ft         = inst[20:16];
    fs         = inst[15:11];
    fd         = inst[10:6];
    if (cop1 && fmt == FMT_MF && low_zero) begin
      d.src_a_v  = 1'b1;
      d.src_a    = fs[4:1];
      d.slot.mfc = 1'b1;
      d.slot.rt  = ft;
    end else if (cop1 && fmt == FMT_MT && low_zero) begin
      d.slot.dst_v = 1'b1;
      d.slot.dst   = fs[4:1];
      d.slot.mtc   = 1'b1;
      d.slot.rt    = ft;
    end else if (cop1 && fmt[4]) begin
      d.src_a_v    = 1'b1;
      d.src_a      = fs[4:1];
      d.src_b_v    = 1'b1;
      d.src_b      = ft[4:1];
      d.slot.dst_v = 1'b1;
      d.slot.dst   = fd[4:1];
    end
    return d;
  endfunction

endpackage

// File: rtl/fpu_inst_fifo.sv
// DEPTH x W synchronous instruction FIFO with flush. The head word is shown
// combinationally; pushes into a full FIFO and pops from an empty one are ignored.
module fpu_inst_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  // Storage array.
  // NOTE: the data array has no reset; count and pointers alone say which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; flush empties, pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fpu_issue.sv
// Issue stage in front of the FPU. Buffers COP1 words, issues one per cycle,
// inserts NOP bubbles on FPR RAW hazards against the ID and EX slots, freezes
// under fpu_hold and steers the GPR port for MFC1/MTC1 in WB.
module fpu_issue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [31:0]      in_inst,
  output logic             in_ready,
  input  logic             flush,
  input  logic             fpu_hold,
  output logic [31:0]      fpu_inst,
  output logic             wb_mfc_we,
  output logic [4:0]       wb_gpr_waddr,
  output logic [4:0]       wb_gpr_raddr,
  output logic             busy,
  output logic [CNT_W-1:0] bubble_cnt
);

  import fpu_defs::*;

  logic [31:0]      head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  dec_t             head_dec;
  trk_slot_t        id_q;
  trk_slot_t        ex_q;
  trk_slot_t        wb_q;
  logic [31:0]      inst_q;
  logic [CNT_W-1:0] bub_q;
  logic             blocked;
  logic             issue_ok;
  logic             bubble;
  logic             wb_unused_ok;

  assign push     = in_valid && in_ready;
  assign in_ready = !fifo_full;
  assign head_dec = decode(head);

  fpu_inst_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (in_inst),
    .pop       (issue_ok),
    .flush     (flush),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Hazard check of the head against ID and EX; WB writes the FPR at the issue edge.
  // NOTE: every output of an always_comb gets a default first so no latch is inferred.
  always_comb begin
    blocked  = 1'b0;
    issue_ok = 1'b0;
    bubble   = 1'b0;
    if (head_dec.src_a_v &&
        ((id_q.valid && id_q.dst_v && id_q.dst == head_dec.src_a) ||
         (ex_q.valid && ex_q.dst_v && ex_q.dst == head_dec.src_a)))
      blocked = 1'b1;
    if (head_dec.src_b_v &&
        ((id_q.valid && id_q.dst_v && id_q.dst == head_dec.src_b) ||
         (ex_q.valid && ex_q.dst_v && ex_q.dst == head_dec.src_b)))
      blocked = 1'b1;
    if (!fpu_hold && !flush && !fifo_empty) begin
      issue_ok = !blocked;
      bubble   = blocked;
    end
  end

  // Tracker shift, issue register and saturating bubble counter; all frozen on hold.
  // NOTE: sequential state uses non-blocking assignments so every slot samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q <= NOP_WORD;
      id_q   <= '0;
      ex_q   <= '0;
      wb_q   <= '0;
      bub_q  <= '0;
    end else if (!fpu_hold) begin
      wb_q <= ex_q;
      ex_q <= id_q;
      if (issue_ok) begin
        id_q   <= head_dec.slot;
        inst_q <= head;
      end else begin
        id_q   <= '0;
        inst_q <= NOP_WORD;
      end
      if (bubble && bub_q != '1) bub_q <= bub_q + CNT_W'(1);
    end
  end

  assign fpu_inst     = inst_q;
  assign bubble_cnt   = bub_q;
  assign wb_mfc_we    = wb_q.valid && wb_q.mfc;
  assign wb_gpr_waddr = wb_q.rt;
  assign wb_gpr_raddr = (wb_q.valid && wb_q.mtc) ? wb_q.rt : 5'd0;
  assign busy         = !fifo_empty || id_q.valid || ex_q.valid || wb_q.valid;
  assign wb_unused_ok = ^{wb_q.dst_v, wb_q.dst};

endmodule
